// File: rtl/alu_pkg.sv
// Shared datapath constants and ALU select encodings for the execute stage.
package alu_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned ZERO_REG   = 31;
  localparam int unsigned NUM_REGS   = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_MUL = 3'd3,
    ALU_DIV = 3'd4,
    ALU_AND = 3'd5,
    ALU_OR  = 3'd6
  } alu_sel_e;

endpackage

// File: rtl/flags_reg.sv
// Two-bit condition-flag register (Z, V) with capture enable and async reset.
module flags_reg (
  input  logic clk,
  input  logic reset,
  input  logic flag_we,
  input  logic alu_zero,
  input  logic alu_overflow,
  output logic zero_flag,
  output logic overflow_flag
);

  // Capture ALU flags when enabled, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_flag     <= 1'b0;
      overflow_flag <= 1'b0;
    end else if (flag_we) begin
      zero_flag     <= alu_zero;
      overflow_flag <= alu_overflow;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write architectural register file with hardwired zero register,
// optional same-cycle write forwarding, and a condition-flag register.
module reg_file_2r1w
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = alu_pkg::ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = alu_pkg::ZERO_REG,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flag_we,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  output logic                  zero_flag,
  output logic                  overflow_flag
);

  localparam int unsigned          DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR   = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_live;

  // A write is real only when enabled, out of reset and not aimed at XZR.
  assign wr_live = wr_en && !reset && (wr_addr != ZR);

  // Register array: async clear, one write per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read port 1: array lookup, optional forwarding, XZR forced to zero.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if (rd_addr1 == ZR) rd_data1 = '0;
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    rd_data2 = regs[rd_addr2];
    if ((BYPASS != 0) && wr_live && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    if (rd_addr2 == ZR) rd_data2 = '0;
  end

  flags_reg u_flags (
    .clk           (clk),
    .reset         (reset),
    .flag_we       (flag_we),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .zero_flag     (zero_flag),
    .overflow_flag (overflow_flag)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: two instances (forwarding on/off) share stimulus.
module tb_reg_file_2r1w;
  import alu_pkg::*;

  logic                  clk;
  logic                  reset;
  logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2, wr_addr;
  logic                  wr_en, flag_we, alu_zero, alu_overflow;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic                  b_zf, b_vf, n_zf, n_vf;

  int tests  = 0;
  int failed = 0;

  // Reference state: plain array of register contents plus two flag bits.
  logic [DATA_WIDTH-1:0] model [32];
  logic                  m_zf, m_vf;

  reg_file_2r1w #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .zero_flag(b_zf), .overflow_flag(b_vf));

  reg_file_2r1w #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flag_we(flag_we), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .zero_flag(n_zf), .overflow_flag(n_vf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the spec rules.
  function automatic logic [63:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd31) return '0;
    if (byp && wr_en && !reset && wr_addr == a) return wr_data;
    return model[a];
  endfunction

  function automatic logic [63:0] alu_ref(input alu_sel_e op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      default: return '0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
    m_zf = 1'b0;
    m_vf = 1'b0;
  endtask

  // Advance one edge, applying the reference model's view of that edge.
  task automatic tick();
    if (reset) begin
      model_clear();
    end else begin
      if (wr_en && wr_addr != 5'd31) model[wr_addr] = wr_data;
      if (flag_we) begin m_zf = alu_zero; m_vf = alu_overflow; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, " byp rd1"}, b_rd1, exp_rd(rd_addr1, 1'b1));
    check({tag, " byp rd2"}, b_rd2, exp_rd(rd_addr2, 1'b1));
    check({tag, " nob rd1"}, n_rd1, exp_rd(rd_addr1, 1'b0));
    check({tag, " nob rd2"}, n_rd2, exp_rd(rd_addr2, 1'b0));
  endtask

  task automatic check_flags(input string tag);
    check({tag, " zf"}, 64'(b_zf), 64'(m_zf));
    check({tag, " vf"}, 64'(b_vf), 64'(m_vf));
    check({tag, " nob zf"}, 64'(n_zf), 64'(m_zf));
    check({tag, " nob vf"}, 64'(n_vf), 64'(m_vf));
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra1, ra2;
    logic        fwe, z, v;
    logic [63:0] b1, b2;   // pre-edge reads, forwarding on
    logic [63:0] n1, n2;   // pre-edge reads, forwarding off
    logic        zf, vf;   // flags after the edge
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{1'b1, 5'd1,  64'd5,  5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 64'd5,  64'd0,  64'd0,  64'd0,  1'b0, 1'b0};
    vt[1]  = '{1'b1, 5'd2,  64'd10, 5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 64'd5,  64'd10, 64'd5,  64'd0,  1'b0, 1'b0};
    vt[2]  = '{1'b0, 5'd0,  64'd0,  5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 64'd5,  64'd10, 64'd5,  64'd10, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 5'd0,  64'd0,  5'd31, 5'd30, 1'b0, 1'b0, 1'b0, 64'd0,  64'd0,  64'd0,  64'd0,  1'b0, 1'b0};
    vt[5]  = '{1'b1, 5'd7,  64'd25, 5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 64'd25, 64'd25, 64'd0,  64'd0,  1'b0, 1'b0};
    vt[6]  = '{1'b0, 5'd0,  64'd0,  5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 64'd25, 64'd25, 64'd25, 64'd25, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 5'd0,  64'd0,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 64'd5,  64'd10, 64'd5,  64'd10, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 5'd0,  64'd0,  5'd1,  5'd2,  1'b0, 1'b0, 1'b1, 64'd5,  64'd10, 64'd5,  64'd10, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 5'd0,  64'd0,  5'd1,  5'd2,  1'b1, 1'b0, 1'b1, 64'd5,  64'd10, 64'd5,  64'd10, 1'b0, 1'b1};
    vt[10] = '{1'b0, 5'd4,  64'hDEAD_BEEF_0BAD_F00D, 5'd4, 5'd7, 1'b0, 1'b0, 1'b0, 64'd0, 64'd25, 64'd0, 64'd25, 1'b0, 1'b1};
    vt[11] = '{1'b0, 5'd0,  64'd0,  5'd4,  5'd1,  1'b0, 1'b0, 1'b0, 64'd0,  64'd5,  64'd0,  64'd5,  1'b0, 1'b1};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; flag_we = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    model_clear();
    #12;
    check_flags("reset init");
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized traffic against the array model.
    for (int c = 0; c < 300; c++) begin
      wr_en        = 1'($urandom_range(0, 1));
      wr_addr      = 5'($urandom);
      wr_data      = {32'($urandom), 32'($urandom)};
      rd_addr1     = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr2     = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom);
      flag_we      = 1'($urandom_range(0, 1));
      alu_zero     = 1'($urandom);
      alu_overflow = 1'($urandom);
      #1;
      check_reads("rand");
      tick();
      check_flags("rand");
    end

    // Short async reset pulse between edges; everything reads zero at once.
    wr_en = 1'b0; flag_we = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_clear();
    for (int a = 0; a < 32; a++) begin
      rd_addr1 = 5'(a);
      rd_addr2 = 5'(31 - a);
      #0.1;
      check("pulse byp rd1", b_rd1, 64'd0);
      check("pulse byp rd2", b_rd2, 64'd0);
      check("pulse nob rd1", n_rd1, 64'd0);
      check("pulse nob rd2", n_rd2, 64'd0);
    end
    check_flags("pulse");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table from a clean state.
    for (int i = 0; i < 12; i++) begin
      wr_en = vt[i].we; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_addr1 = vt[i].ra1; rd_addr2 = vt[i].ra2;
      flag_we = vt[i].fwe; alu_zero = vt[i].z; alu_overflow = vt[i].v;
      #1;
      check($sformatf("vec%0d byp rd1", i), b_rd1, vt[i].b1);
      check($sformatf("vec%0d byp rd2", i), b_rd2, vt[i].b2);
      check($sformatf("vec%0d nob rd1", i), n_rd1, vt[i].n1);
      check($sformatf("vec%0d nob rd2", i), n_rd2, vt[i].n2);
      tick();
      check($sformatf("vec%0d zf", i), 64'(b_zf), 64'(vt[i].zf));
      check($sformatf("vec%0d vf", i), 64'(b_vf), 64'(vt[i].vf));
    end

    // Operands feed an ADD: r1 + r2 = 15.
    wr_en = 1'b0; flag_we = 1'b0; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    #1;
    check("alu add", alu_ref(ALU_ADD, b_rd1, b_rd2), 64'd15);

    // Reset coincident with a write and a flag capture loses both.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'd8; rd_addr1 = 5'd3; rd_addr2 = 5'd3;
    flag_we = 1'b1; alu_zero = 1'b1; alu_overflow = 1'b0;
    #1 reset = 1'b1;
    tick();
    check("rstmid r3 byp", b_rd1, 64'd0);
    check("rstmid r3 nob", n_rd1, 64'd0);
    check("rstmid zf", 64'(b_zf), 64'd0);
    check("rstmid vf", 64'(b_vf), 64'd0);
    reset = 1'b0;
    #1;
    check("rstmid fwd after deassert", b_rd1, 64'd8);
    check("rstmid nob before edge", n_rd1, 64'd0);
    tick();
    wr_en = 1'b0; flag_we = 1'b0;
    #1;
    check("rstmid r3 written byp", b_rd1, 64'd8);
    check("rstmid r3 written nob", n_rd2, 64'd8);
    check_flags("rstmid after");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 64-bit, 2-read/1-write architectural register file with a condition-flag register.
- Sits directly upstream of the ALU: rd_data1/rd_data2 drive ALU a_in/b_in, and the ALU result is written back through the write port.
- Also captures the ALU zero/overflow outputs into a flags register when the instruction sets flags, for later conditional branches.
- Single clock domain; asynchronous active-high reset.

Parameters:
- DATA_WIDTH, 64, width of each register and of the read/write data.
- ADDR_WIDTH, 5, register address width; number of registers = 2**ADDR_WIDTH (32).
- ZERO_REG, 31, index of the hardwired-zero register (XZR).
- BYPASS, 1, 1 = write-to-read forwarding in the same cycle; 0 = reads return pre-write contents.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- rd_addr1  input  ADDR_WIDTH  read port 1 address.
- rd_addr2  input  ADDR_WIDTH  read port 2 address.
- rd_data1  output  DATA_WIDTH  read port 1 data (to ALU a_in).
- rd_data2  output  DATA_WIDTH  read port 2 data (to ALU b_in).
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data (ALU result or load data).
- flag_we  input  1  capture ALU flags this cycle.
- alu_zero  input  1  ALU zero output.
- alu_overflow  input  1  ALU overflow output.
- zero_flag  output  1  registered Z flag.
- overflow_flag  output  1  registered V flag.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset response:
  - On reset assertion, immediately and independent of clk, all registers clear to 0, and zero_flag and overflow_flag clear to 0.
  - rd_data1/rd_data2 therefore read 0 for every address while reset is held.
- Reset dominance: reset overrides wr_en and flag_we in the same cycle.
  - A write or flag capture coincident with reset is lost.
  - Deassertion mid-program resumes normally on the next rising edge.
- Write:
  - On the rising clk edge with wr_en=1 and wr_addr!=ZERO_REG, reg[wr_addr] <= wr_data.
  - A write to ZERO_REG is silently discarded.
  - Write latency is 1 cycle.
- Read:
  - Combinational, 0-cycle latency from address to data.
  - Reading ZERO_REG always returns 0, including when a write to ZERO_REG is pending.
- Bypass (BYPASS=1):
  - If wr_en=1, wr_addr==rd_addrN and rd_addrN!=ZERO_REG, then rd_dataN = wr_data in the same cycle.
  - This supports single-cycle read-after-write.
  - It applies independently to both ports.
- Bypass disabled (BYPASS=0): rd_dataN shows the old contents until after the edge.
- Same-address reads: both read ports may address the same register and then return identical data.
- Flags:
  - On the rising clk edge with flag_we=1, zero_flag <= alu_zero and overflow_flag <= alu_overflow.
  - With flag_we=0, the flags hold.
  - Flag outputs are registered only; they are never bypassed.
- Simultaneous events: wr_en and flag_we in the same cycle are independent, and both take effect.
- X-safety: with wr_en=0, wr_addr and wr_data are don't-care and must not disturb state.

Decomposition:
- Shared package alu_pkg:
  - DATA_WIDTH=64, ADDR_WIDTH=5, ZERO_REG=31.
  - ALU select encodings ADD=3'd1, SUB=3'd2, MUL=3'd3, DIV=3'd4, AND=3'd5, OR=3'd6.
- Sub-module: flags_reg, the 2-bit enable-gated flag register with async reset.
  - It is small but reused by the branch unit bench.
- The register array and bypass muxes stay in reg_file_2r1w.

Test Plan:
- Reset:
  - Stimulus: pulse reset high for 3 ns between clock edges.
  - Required response: all 32 registers read 0 via both ports, zero_flag=0, overflow_flag=0, without waiting for any clk edge.
- Write/read:
  - Stimulus: write 64'h0000_0000_0000_0005 to r1 and 64'd10 to r2 on consecutive cycles, then read rd_addr1=1, rd_addr2=2.
  - Required response: rd_data1=5, rd_data2=10. Also check that an ADD through the ALU gives 15.
- Zero register:
  - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF to r31.
  - Required response: rd_data1 at rd_addr1=31 reads 0 during and after the write; r30 remains unchanged.
- Bypass:
  - Stimulus: with BYPASS=1, in one cycle set wr_en=1, wr_addr=7, wr_data=64'd25, rd_addr1=7, rd_addr2=7.
  - Required response: both ports read 25 before the edge.
  - Repeat with BYPASS=0: ports read the old value (0) until after the edge.
- Flags:
  - Stimulus: flag_we=1, alu_zero=1, alu_overflow=0 at edge N; then flag_we=0, alu_zero=0, alu_overflow=1 at edge N+1.
  - Required response: zero_flag=1, overflow_flag=0 after N, and both hold after N+1.
  - Then flag_we=1, alu_overflow=1: overflow_flag=1.
- Reset mid-operation:
  - Stimulus: assert reset in the same cycle as wr_en=1, wr_addr=3, wr_data=64'd8 and flag_we=1, alu_zero=1.
  - Required response: r3 reads 0 and zero_flag=0 after the edge.
  - After deassertion, a write of 8 to r3 succeeds on the next edge.
